// File: rtl/meter_pkg.sv
// Shared types and constants for the level-meter sequencer.
// State encoding, one-hot class codes and the ratio scale factor.
package meter_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_MEAN_REQ,
    S_MEAN_WAIT,
    S_SQRT_REQ,
    S_SQRT_ARM,
    S_SQRT_WAIT,
    S_RAT_REQ,
    S_RAT_WAIT,
    S_CLASSIFY
  } state_e;

  localparam logic [2:0] RES_HI  = 3'b001;
  localparam logic [2:0] RES_MID = 3'b010;
  localparam logic [2:0] RES_LO  = 3'b100;

  localparam int unsigned RATIO_SCALE = 100;

endpackage

// File: rtl/meter_classify.sv
// Crest-ratio classifier: threshold compare into a registered one-hot code.
// Ports: clk, rst_n, i_load (capture), i_ratio (pct), o_result (class).
// Macro METER_SEQ_HYST_EN adds +/-3 point hysteresis around thresholds.
module meter_classify
  import meter_pkg::*;
#(
  parameter int HI_PCT  = 75,
  parameter int MID_PCT = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_ratio,
  output logic [2:0] o_result
);

  localparam logic [8:0] HI_TH  = 9'(HI_PCT);
  localparam logic [8:0] MID_TH = 9'(MID_PCT);

  logic [8:0] w_r;
  logic [2:0] w_plain;
  logic [2:0] w_next;
  logic [2:0] r_result;

  assign w_r = {1'b0, i_ratio};

  always_comb begin
    w_plain = RES_LO;
    if (w_r >= HI_TH)
      w_plain = RES_HI;
    else if (w_r >= MID_TH)
      w_plain = RES_MID;
  end

`ifdef METER_SEQ_HYST_EN
  localparam int HYST = 3;
  localparam logic [8:0] HI_UP  = 9'(HI_PCT + HYST);
  localparam logic [8:0] HI_DN  = 9'(HI_PCT - HYST);
  localparam logic [8:0] MID_UP = 9'(MID_PCT + HYST);
  localparam logic [8:0] MID_DN = 9'(MID_PCT - HYST);

  // Set once the first class is stored; before that no history exists.
  logic r_seen;

  always_comb begin
    w_next = w_plain;
    if (r_seen) begin
      unique case (r_result)
        RES_HI: begin
          w_next = RES_HI;
          if (w_r < MID_DN)
            w_next = RES_LO;
          else if (w_r < HI_DN)
            w_next = RES_MID;
        end
        RES_MID: begin
          w_next = RES_MID;
          if (w_r >= HI_UP)
            w_next = RES_HI;
          else if (w_r < MID_DN)
            w_next = RES_LO;
        end
        RES_LO: begin
          w_next = RES_LO;
          if (w_r >= HI_UP)
            w_next = RES_HI;
          else if (w_r >= MID_UP)
            w_next = RES_MID;
        end
        default: w_next = w_plain;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_seen <= 1'b0;
    else if (i_load)
      r_seen <= 1'b1;
  end
`else
  assign w_next = w_plain;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_result <= 3'b000;
    else if (i_load)
      r_result <= w_next;
  end

  assign o_result = r_result;

endmodule

// File: rtl/meter_seq.sv
// Level-meter sequencer: mean=sum/cnt, rms=sqrt(mean), ratio=rms*100/peak
// on a shared divider and sqrt unit, then a one-hot crest class.
// Ports: window in (win_*, peak), divider and sqrt handshakes,
// results (rms, ratio_pct, result, result_vld), status (busy, err, ovr).
// Macro METER_SEQ_HYST_EN enables class hysteresis in meter_classify.
module meter_seq
  import meter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int HI_PCT      = 75,
  parameter int MID_PCT     = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        win_vld,
  input  logic [63:0] win_sum,
  input  logic [63:0] win_cnt,
  input  logic [15:0] peak,
  output logic        div_start,
  output logic [63:0] div_dividend,
  output logic [63:0] div_divisor,
  input  logic [63:0] div_quotient,
  input  logic        div_done,
  output logic [63:0] sqrt_din,
  output logic        sqrt_valid,
  input  logic        sqrt_busy,
  input  logic [31:0] sqrt_root,
  output logic [31:0] rms,
  output logic [7:0]  ratio_pct,
  output logic [2:0]  result,
  output logic        result_vld,
  output logic        busy,
  output logic        err,
  output logic        ovr
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_e        r_state;
  state_e        w_next;
  logic [TW-1:0] r_tmo;
  logic          w_tmo_end;
  logic          w_accept;
  logic          w_err_set;
  logic          w_wait;

  logic [63:0] r_div_dividend;
  logic [63:0] r_div_divisor;
  logic [63:0] r_sqrt_din;
  logic [15:0] r_peak;
  logic [31:0] r_rms_int;
  logic [7:0]  r_ratio_int;
  logic [31:0] r_rms;
  logic [7:0]  r_ratio;
  logic        r_result_vld;
  logic        r_err;
  logic        r_ovr;
  logic        w_load;
  logic [2:0]  w_result;

  assign w_tmo_end = (r_tmo == TMO_LAST);
  assign w_wait = (r_state == S_MEAN_WAIT) ||
                  (r_state == S_SQRT_ARM)  ||
                  (r_state == S_SQRT_WAIT) ||
                  (r_state == S_RAT_WAIT);

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (win_vld) begin
          if (win_cnt == 64'd0 || peak == 16'd0) begin
            w_err_set = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = S_MEAN_REQ;
          end
        end
      end
      S_MEAN_REQ: w_next = S_MEAN_WAIT;
      S_MEAN_WAIT: begin
        if (div_done)
          w_next = S_SQRT_REQ;
        else if (w_tmo_end) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_SQRT_REQ: w_next = S_SQRT_ARM;
      S_SQRT_ARM: begin
        if (sqrt_busy)
          w_next = S_SQRT_WAIT;
        else if (w_tmo_end) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_SQRT_WAIT: begin
        if (!sqrt_busy)
          w_next = S_RAT_REQ;
        else if (w_tmo_end) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_RAT_REQ: w_next = S_RAT_WAIT;
      S_RAT_WAIT: begin
        if (div_done)
          w_next = S_CLASSIFY;
        else if (w_tmo_end) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_CLASSIFY: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Any state change restarts the count, so each wait starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_tmo <= '0;
    else if (w_next != r_state)
      r_tmo <= '0;
    else if (w_wait)
      r_tmo <= r_tmo + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
      r_sqrt_din     <= '0;
      r_peak         <= '0;
      r_rms_int      <= '0;
      r_ratio_int    <= '0;
    end else begin
      if (w_accept) begin
        r_div_dividend <= win_sum;
        r_div_divisor  <= win_cnt;
        r_peak         <= peak;
      end
      if (r_state == S_MEAN_WAIT && div_done)
        r_sqrt_din <= div_quotient;
      // Ratio operands are loaded as the root lands, ready for RAT_REQ.
      if (r_state == S_SQRT_WAIT && !sqrt_busy) begin
        r_rms_int      <= sqrt_root;
        r_div_dividend <= 64'(sqrt_root) * 64'(RATIO_SCALE);
        r_div_divisor  <= {48'd0, r_peak};
      end
      if (r_state == S_RAT_WAIT && div_done)
        r_ratio_int <= (div_quotient > 64'd255) ?
                       8'hFF : div_quotient[7:0];
    end
  end

  assign w_load = (r_state == S_CLASSIFY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rms        <= '0;
      r_ratio      <= '0;
      r_result_vld <= 1'b0;
      r_err        <= 1'b0;
      r_ovr        <= 1'b0;
    end else begin
      r_result_vld <= w_load;
      r_err        <= w_err_set;
      r_ovr        <= win_vld && (r_state != S_IDLE);
      if (w_load) begin
        r_rms   <= r_rms_int;
        r_ratio <= r_ratio_int;
      end
    end
  end

  meter_classify #(
    .HI_PCT  (HI_PCT),
    .MID_PCT (MID_PCT)
  ) u_cls (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_ratio  (r_ratio_int),
    .o_result (w_result)
  );

  assign div_start    = (r_state == S_MEAN_REQ) ||
                        (r_state == S_RAT_REQ);
  assign sqrt_valid   = (r_state == S_SQRT_REQ);
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;
  assign sqrt_din     = r_sqrt_din;
  assign rms          = r_rms;
  assign ratio_pct    = r_ratio;
  assign result       = w_result;
  assign result_vld   = r_result_vld;
  assign busy         = (r_state != S_IDLE);
  assign err          = r_err;
  assign ovr          = r_ovr;

endmodule
